frame_dma: RTL and testbench

FRAME_DMA -- requirements
Module: frame_dma

---
 rtl/frame_dma.sv | 156 +++++++++++++++
 tb/tb_frame_dma.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_dma.sv
// Frame DMA: latches one 256-bit frame and writes it as an AHB-Lite INCR8 word burst
// into a ring of NFRAMES 32-byte slots starting at baseAddr.
module frame_dma #(
  parameter int unsigned NFRAMES = 16
) (
  input  logic                               hclk,
  input  logic                               hreset,
  input  logic                               enable,
  input  logic                               valid,
  input  logic [255:0]                       pdata,
  input  logic [31:0]                        baseAddr,
  output logic                               ack,
  output logic                               busy,
  output logic                               error,
  output logic [15:0]                        droppedCount,
  output logic [$clog2(NFRAMES)-1:0]         frameIdx,
  output logic [31:0]                        haddr,
  output logic [1:0]                         htrans,
  output logic                               hwrite,
  output logic [2:0]                         hsize,
  output logic [2:0]                         hburst,
  output logic [31:0]                        hwdata,
  input  logic                               hready,
  input  logic [1:0]                         hresp
);

  localparam int unsigned IdxW = $clog2(NFRAMES);

  typedef enum logic [1:0] {StIdle, StBurst, StLast, StErr} state_e;

  state_e            state_q, state_d;
  logic [2:0]        beat_q, beat_d;
  logic [255:0]      frame_q, frame_d;
  logic [26:0]       base_q, base_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [31:0]       hwdata_q, hwdata_d;
  logic              ack_q, ack_d;
  logic              error_q, error_d;
  logic [15:0]       dropped_q, dropped_d;
  logic              err_resp;

  // First cycle of a two-cycle non-OKAY response; RETRY/SPLIT are handled as ERROR.
  assign err_resp = (hresp != 2'b00) && !hready;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    frame_d   = frame_q;
    base_d    = base_q;
    idx_d     = idx_q;
    hwdata_d  = hwdata_q;
    ack_d     = 1'b0;
    error_d   = error_q;
    dropped_d = dropped_q;

    unique case (state_q)
      StIdle: begin
        if (enable && valid) begin
          frame_d = pdata;
          base_d  = baseAddr[31:5];
          beat_d  = 3'd0;
          ack_d   = 1'b1;
          state_d = StBurst;
        end
      end
      StBurst: begin
        if (err_resp) begin
          state_d = StErr;
        end else if (hready) begin
          hwdata_d = frame_q[{beat_q, 5'd0} +: 32];
          if (beat_q == 3'd7) begin
            state_d = StLast;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
      StLast: begin
        if (err_resp) begin
          state_d = StErr;
        end else if (hready) begin
          idx_d   = idx_q + IdxW'(1);
          state_d = StIdle;
        end
      end
      StErr: begin
        if (hready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if ((state_q != StIdle) && valid && (dropped_q != 16'hFFFF)) begin
      dropped_d = dropped_q + 16'd1;
    end

    if ((state_q == StIdle) && !enable) begin
      idx_d = '0;
    end

    // Entering ERR wins over a same-cycle clear so the abort is never lost.
    if (!enable) begin
      error_d = 1'b0;
    end
    if (((state_q == StBurst) || (state_q == StLast)) && err_resp) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q   <= StIdle;
      beat_q    <= 3'd0;
      frame_q   <= '0;
      base_q    <= '0;
      idx_q     <= '0;
      hwdata_q  <= '0;
      ack_q     <= 1'b0;
      error_q   <= 1'b0;
      dropped_q <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      frame_q   <= frame_d;
      base_q    <= base_d;
      idx_q     <= idx_d;
      hwdata_q  <= hwdata_d;
      ack_q     <= ack_d;
      error_q   <= error_d;
      dropped_q <= dropped_d;
    end
  end

  always_comb begin
    htrans = 2'b00;
    haddr  = 32'h0;
    if (state_q == StBurst) begin
      haddr = {base_q, 5'd0} + 32'({idx_q, 5'd0}) + 32'({beat_q, 2'd0});
      if (!err_resp) begin
        htrans = (beat_q == 3'd0) ? 2'b10 : 2'b11;
      end
    end
  end

  assign hwrite       = (state_q == StBurst) || (state_q == StLast);
  assign hsize        = 3'b010;
  assign hburst       = 3'b101;
  assign hwdata       = hwdata_q;
  assign ack          = ack_q;
  assign busy         = (state_q != StIdle);
  assign error        = error_q;
  assign droppedCount = dropped_q;
  assign frameIdx     = idx_q;

endmodule

// File: tb/tb_frame_dma.sv
// Directed bench for frame_dma: a bus monitor pops expected (address, word) pairs from a
// scoreboard queue as each data phase completes; directed steps check control timing.
module tb_frame_dma;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic         hclk = 1'b0;
  logic         hreset, enable, valid;
  logic [255:0] pdata;
  logic [31:0]  baseAddr;
  logic         ack, busy, error;
  logic [15:0]  droppedCount;
  logic [3:0]   frameIdx;
  logic [31:0]  haddr, hwdata;
  logic [1:0]   htrans;
  logic         hwrite;
  logic [2:0]   hsize, hburst;
  logic         hready;
  logic [1:0]   hresp;

  frame_dma #(.NFRAMES(16)) dut (
    .hclk(hclk), .hreset(hreset), .enable(enable), .valid(valid), .pdata(pdata),
    .baseAddr(baseAddr), .ack(ack), .busy(busy), .error(error),
    .droppedCount(droppedCount), .frameIdx(frameIdx), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
    .hready(hready), .hresp(hresp)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } beat_t;

  beat_t       exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          n_ack = 0;
  int unsigned mdl_idx = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [255:0] d, input int unsigned idx, input int nbeats);
    beat_t b;
    for (int k = 0; k < nbeats; k++) begin
      b.a = BASE + 32'(idx * 32) + 32'(k * 4);
      b.d = d[k*32 +: 32];
      exp_q.push_back(b);
    end
  endtask

  // Bus monitor: hold checks on stalls, scoreboard pop on each OKAY data phase.
  logic        dp_valid = 1'b0;
  logic [31:0] dp_addr;
  logic        stall_prev = 1'b0;
  logic        prev_dp;
  logic [31:0] prev_addr, prev_wdata;
  logic [1:0]  prev_trans;

  always @(negedge hclk) begin
    if (hreset) begin
      dp_valid   = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_haddr", haddr, prev_addr);
        check("hold_htrans", 32'(htrans), 32'(prev_trans));
        if (prev_dp) check("hold_hwdata", hwdata, prev_wdata);
      end
      if (ack) n_ack++;
      if (dp_valid && hready) begin
        if (hresp == 2'b00) begin
          check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            check("sb_addr", dp_addr, exp_q[0].a);
            check("sb_data", hwdata, exp_q[0].d);
            void'(exp_q.pop_front());
          end
        end
        dp_valid = 1'b0;
      end
      if (htrans[1] && hready) begin
        dp_valid = 1'b1;
        dp_addr  = haddr;
      end
      stall_prev = !hready && (hresp == 2'b00) && (htrans[1] || dp_valid);
      prev_dp    = dp_valid;
      prev_addr  = haddr;
      prev_wdata = hwdata;
      prev_trans = htrans;
    end
  end

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) tick();
    check("wait_idle", 32'(busy), 32'd0);
  endtask

  task automatic run_frame(input logic [255:0] d);
    pdata = d;
    valid = 1'b1;
    push_frame(d, mdl_idx, 8);
    tick();
    valid = 1'b0;
    wait_idle();
    mdl_idx = (mdl_idx + 1) % 16;
  endtask

  function automatic logic [255:0] rand_frame();
    logic [255:0] d;
    for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  logic [255:0] d;
  int           acks0;

  initial begin
    hreset = 1'b1; enable = 1'b0; valid = 1'b0; pdata = '0;
    baseAddr = BASE; hready = 1'b1; hresp = 2'b00;
    tick(); tick();
    check("rst_htrans", 32'(htrans), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_dropped", 32'(droppedCount), 32'd0);
    check("rst_idx", 32'(frameIdx), 32'd0);
    check("rst_haddr", haddr, 32'd0);
    check("rst_hwdata", hwdata, 32'd0);
    check("rst_hwrite", 32'(hwrite), 32'd0);
    check("rst_hsize", 32'(hsize), 32'd2);
    check("rst_hburst", 32'(hburst), 32'd5);

    // Single frame, hready high: exact cycle timing.
    hreset = 1'b0; enable = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) d[k*32 +: 32] = 32'h1111_1111 * (k + 1);
    pdata = d; valid = 1'b1;
    push_frame(d, 0, 8);
    tick();
    valid = 1'b0;
    check("c1_ack", 32'(ack), 32'd1);
    check("c1_nonseq", 32'(htrans), 32'd2);
    check("c1_haddr", haddr, BASE);
    check("c1_hwrite", 32'(hwrite), 32'd1);
    for (int c = 2; c <= 8; c++) begin
      tick();
      check("seq_htrans", 32'(htrans), 32'd3);
      check("seq_haddr", haddr, BASE + 32'((c - 1) * 4));
      if (c == 2) check("ack_pulse", 32'(ack), 32'd0);
    end
    tick();
    check("c9_htrans", 32'(htrans), 32'd0);
    check("c9_hwdata", hwdata, 32'h8888_8888);
    check("c9_busy", 32'(busy), 32'd1);
    tick();
    check("c10_busy", 32'(busy), 32'd0);
    check("c10_idx", 32'(frameIdx), 32'd1);
    mdl_idx = 1;

    // Random hready stalls.
    acks0 = n_ack;
    d = rand_frame();
    pdata = d; valid = 1'b1;
    push_frame(d, mdl_idx, 8);
    tick();
    valid = 1'b0;
    for (int i = 0; i < 300 && busy; i++) begin
      hready = 1'($urandom_range(0, 1));
      tick();
    end
    hready = 1'b1;
    wait_idle();
    mdl_idx = 2;
    check("stall_acks", 32'(n_ack - acks0), 32'd1);
    check("stall_idx", 32'(frameIdx), 32'd2);

    // Ring wrap: 17th frame lands in slot 0; low base bits ignored.
    baseAddr = BASE | 32'h1F;
    for (int f = 0; f < 14; f++) run_frame(rand_frame());
    check("wrap_idx0", 32'(frameIdx), 32'd0);
    pdata = rand_frame(); valid = 1'b1;
    push_frame(pdata, 0, 8);
    tick();
    valid = 1'b0;
    check("wrap_haddr", haddr, BASE);
    wait_idle();
    mdl_idx = 1;
    check("wrap_idx1", 32'(frameIdx), 32'd1);
    baseAddr = BASE;

    // valid held for 30 cycles: 3 accepted, 27 dropped.
    acks0 = n_ack;
    d = rand_frame();
    for (int f = 0; f < 3; f++) push_frame(d, mdl_idx + f, 8);
    pdata = d; valid = 1'b1;
    repeat (30) tick();
    valid = 1'b0;
    wait_idle();
    mdl_idx = mdl_idx + 3;
    check("hold_acks", 32'(n_ack - acks0), 32'd3);
    check("hold_dropped", 32'(droppedCount), 32'd27);
    check("hold_idx", 32'(frameIdx), 32'(mdl_idx));

    // ERROR response during beat 3's data phase.
    d = rand_frame();
    pdata = d; valid = 1'b1;
    push_frame(d, mdl_idx, 3);
    tick();
    valid = 1'b0;
    repeat (4) tick();
    check("err_pre_htrans", 32'(htrans), 32'd3);
    hready = 1'b0; hresp = 2'b01;
    #1;
    check("err_htrans_idle", 32'(htrans), 32'd0);
    tick();
    check("err_flag", 32'(error), 32'd1);
    check("err_busy", 32'(busy), 32'd1);
    hready = 1'b1;
    tick();
    hresp = 2'b00;
    check("err_idle", 32'(busy), 32'd0);
    check("err_idx", 32'(frameIdx), 32'(mdl_idx));
    run_frame(rand_frame());
    check("err_sticky", 32'(error), 32'd1);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    check("err_clear", 32'(error), 32'd0);
    check("dis_idx", 32'(frameIdx), 32'd0);
    mdl_idx = 0;

    // Reset asserted at beat 4.
    d = rand_frame();
    pdata = d; valid = 1'b1;
    push_frame(d, mdl_idx, 8);
    tick();
    valid = 1'b0;
    repeat (4) tick();
    check("rb_haddr", haddr, BASE + 32'd16);
    hreset = 1'b1;
    tick();
    exp_q.delete();
    check("rb_htrans", 32'(htrans), 32'd0);
    check("rb_busy", 32'(busy), 32'd0);
    check("rb_dropped", 32'(droppedCount), 32'd0);
    check("rb_idx", 32'(frameIdx), 32'd0);
    check("rb_hwdata", hwdata, 32'd0);
    hreset = 1'b0;
    mdl_idx = 0;
    tick();
    run_frame(rand_frame());
    check("rb_clean_idx", 32'(frameIdx), 32'd1);

    tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
